// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the CPU-side virtual memory port arbiter.
// The IO segment base is also used by the memory controller's segment map.
package mem_bus_arbiter_pkg;

   localparam logic [31:0] VIRT_IO_SEGMENT_START = 32'hffff_0000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_ACK     = 2'd3
   } arb_state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

   // Word alignment is required on both ports; fetches may not reach into IO space.
   function automatic logic access_legal(input grant_t gnt, input logic [31:0] addr);
      logic legal;
      legal = (addr[1:0] == 2'b00);
      if (gnt == GNT_I && addr >= VIRT_IO_SEGMENT_START) legal = 1'b0;
      return legal;
   endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Winner selection between fetch (I) and load/store (D) plus the D-streak
// counter that keeps a pending fetch from starving behind data traffic.
module mem_arb_priority
   import mem_bus_arbiter_pkg::*;
#(
   parameter int MAX_D_STREAK = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   arb_en,
   input  logic   reqI,
   input  logic   reqD,
   output logic   gnt_valid,
   output grant_t gnt
);

   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   logic [SW-1:0] streak_q;
   logic          starve;

   assign starve    = reqI && (streak_q >= STREAK_MAX);
   assign gnt_valid = reqI || reqD;
   assign gnt       = (reqD && !starve) ? GNT_D : GNT_I;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         streak_q <= '0;
      end else if (arb_en && gnt_valid) begin
         if (gnt == GNT_D && reqI) begin
            if (streak_q != STREAK_MAX) streak_q <= streak_q + SW'(1);
         end else begin
            streak_q <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory controller's virtual port between instruction fetch (I)
// and load/store (D): arbitrate in IDLE, one memory cycle, capture, acknowledge.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reqI,
   input  logic [31:0] addrI,
   output logic [31:0] rdataI,
   output logic        ackI,
   output logic        errI,
   input  logic        reqD,
   input  logic [31:0] addrD,
   input  logic [31:0] wdataD,
   input  logic        weD,
   output logic [31:0] rdataD,
   output logic        ackD,
   output logic        errD,
   output logic [31:0] addressVirt,
   output logic [31:0] dataInVirt,
   input  logic [31:0] dataOutVirt,
   output logic        wEnVirt
);

   arb_state_t  state_q, state_d;
   grant_t      gnt, gnt_q, ack_gnt;
   logic        gnt_valid;
   logic        arb_en;
   logic        win_legal;
   logic        win_we;
   logic [31:0] win_addr;
   logic [31:0] addr_q, wdata_q;
   logic        we_q;
   logic        enter_ack;

   assign arb_en = (state_q == ST_IDLE);

   mem_arb_priority #(
      .MAX_D_STREAK (MAX_D_STREAK)
   ) u_priority (
      .clk       (clk),
      .rst       (rst),
      .arb_en    (arb_en),
      .reqI      (reqI),
      .reqD      (reqD),
      .gnt_valid (gnt_valid),
      .gnt       (gnt)
   );

   assign win_addr  = (gnt == GNT_D) ? addrD : addrI;
   assign win_we    = (gnt == GNT_D) && weD;
   assign win_legal = access_legal(gnt, win_addr);

   // NOTE: every always_comb output gets a default before any branch so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (gnt_valid) state_d = win_legal ? ST_ACCESS : ST_ACK;
         ST_ACCESS:  state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_ACK;
         ST_ACK:     state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Illegal accesses jump straight from IDLE to ACK, before gnt_q is loaded.
   assign ack_gnt   = (state_q == ST_IDLE) ? gnt : gnt_q;
   assign enter_ack = (state_d == ST_ACK);

   // NOTE: every register here, data included, is reset so a mid-access abort
   // leaves the port and both rdata outputs in a known state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= GNT_I;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         ackI    <= 1'b0;
         errI    <= 1'b0;
         ackD    <= 1'b0;
         errD    <= 1'b0;
         rdataI  <= '0;
         rdataD  <= '0;
      end else begin
         state_q <= state_d;

         if (arb_en && gnt_valid) begin
            gnt_q <= gnt;
            if (win_legal) begin
               addr_q  <= win_addr;
               wdata_q <= wdataD;
               we_q    <= win_we;
            end
         end

         ackI <= enter_ack && (ack_gnt == GNT_I);
         ackD <= enter_ack && (ack_gnt == GNT_D);
         errI <= enter_ack && arb_en && (ack_gnt == GNT_I);
         errD <= enter_ack && arb_en && (ack_gnt == GNT_D);

         if (state_q == ST_CAPTURE && !we_q) begin
            if (gnt_q == GNT_I) rdataI <= dataOutVirt;
            else                rdataD <= dataOutVirt;
         end
      end
   end

   assign addressVirt = addr_q;
   assign dataInVirt  = wdata_q;
   assign wEnVirt     = (state_q == ST_ACCESS) && we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level
// model: per-request legality, ack latency, returned data and grant order.
module tb_mem_bus_arbiter;

   localparam logic [31:0] IO_BASE = 32'hffff_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        reqI = 1'b0, reqD = 1'b0, weD = 1'b0;
   logic [31:0] addrI = '0, addrD = '0, wdataD = '0;
   logic [31:0] rdataI, rdataD, addressVirt, dataInVirt;
   logic [31:0] dataOutVirt = '0;
   logic        ackI, errI, ackD, errD, wEnVirt;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.MAX_D_STREAK(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .reqI        (reqI),
      .addrI       (addrI),
      .rdataI      (rdataI),
      .ackI        (ackI),
      .errI        (errI),
      .reqD        (reqD),
      .addrD       (addrD),
      .wdataD      (wdataD),
      .weD         (weD),
      .rdataD      (rdataD),
      .ackD        (ackD),
      .errD        (errD),
      .addressVirt (addressVirt),
      .dataInVirt  (dataInVirt),
      .dataOutVirt (dataOutVirt),
      .wEnVirt     (wEnVirt)
   );

   // Power-up content of the memory behind the virtual port.
   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'hdead_beef;
      return {a[15:0], ~a[31:16]} ^ 32'h5a3c_0f96;
   endfunction

   function automatic logic [9:0] mem_idx(input logic [31:0] a);
      return {a[31:28], a[7:2]};
   endfunction

   // Synchronous memory: read data valid the cycle after the address.
   logic [31:0]  mem [0:1023];
   bit   [1023:0] written = '0;
   always @(posedge clk) begin
      if (wEnVirt) begin
         mem[mem_idx(addressVirt)]     <= dataInVirt;
         written[mem_idx(addressVirt)] <= 1'b1;
      end
      dataOutVirt <= written[mem_idx(addressVirt)] ? mem[mem_idx(addressVirt)]
                                                   : init_word(addressVirt);
   end

   int          we_total = 0;
   logic [31:0] we_addr = '0, we_data = '0;
   always @(negedge clk) begin
      if (wEnVirt) begin
         we_total <= we_total + 1;
         we_addr  <= addressVirt;
         we_data  <= dataInVirt;
      end
   end

   // Reference model state.
   logic [31:0] exp_mem [logic [31:0]];
   logic [31:0] exp_rd_i = '0, exp_rd_d = '0;

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One fetch and/or one data request raised together; D is served first.
   task automatic run(input logic do_i, input logic [31:0] a_i, input logic do_d,
                      input logic we_d, input logic [31:0] a_d, input logic [31:0] wd_d);
      logic ok_i, ok_d;
      int   li, ld, ci, cd, last, we0;
      ok_i = (a_i[1:0] == 2'b00) && (a_i < IO_BASE);
      ok_d = (a_d[1:0] == 2'b00);
      li   = ok_i ? 4 : 2;
      ld   = ok_d ? 4 : 2;
      cd   = do_d ? ld : 0;
      ci   = do_i ? (do_d ? ld + li : li) : 0;
      last = (ci > cd) ? ci : cd;
      @(posedge clk); #1;
      we0 = we_total;
      reqI = do_i; addrI = a_i;
      reqD = do_d; addrD = a_d; weD = we_d; wdataD = wd_d;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         check("ackI timing", 32'(ackI), 32'(k == ci));
         check("ackD timing", 32'(ackD), 32'(k == cd));
         if (do_d && k == cd) begin
            if (ok_d && !we_d) exp_rd_d = exp_read(a_d);
            if (ok_d && we_d)  exp_mem[a_d] = wd_d;
            check("errD", 32'(errD), 32'(!ok_d));
            check("rdataD", rdataD, exp_rd_d);
         end
         if (do_i && k == ci) begin
            if (ok_i) exp_rd_i = exp_read(a_i);
            check("errI", 32'(errI), 32'(!ok_i));
            check("rdataI", rdataI, exp_rd_i);
         end
         if (k == cd || k == ci) begin
            @(posedge clk); #1;
            if (k == cd) reqD = 1'b0;
            if (k == ci) reqI = 1'b0;
         end
      end
      @(negedge clk);
      check("wEnVirt cycles", 32'(we_total - we0), 32'(do_d && we_d && ok_d));
      if (do_d && we_d && ok_d) begin
         check("store dataInVirt", we_data, wd_d);
         check("store address", we_addr, a_d);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] base;
      base = 32'h2000_0000 + 32'(4 * $urandom_range(0, 15));
      case ($urandom_range(0, 7))
         0:       return base + 32'($urandom_range(1, 3));
         1:       return IO_BASE + 32'(4 * $urandom_range(0, 15));
         default: return base;
      endcase
   endfunction

   initial begin
      int          n;
      logic        exp_is_i;
      logic        r_we;
      logic [31:0] r_ai, r_ad;
      int          mode;

      // Reset state
      #12;
      check("rst ackI", 32'(ackI), 32'd0);
      check("rst ackD", 32'(ackD), 32'd0);
      check("rst errI", 32'(errI), 32'd0);
      check("rst errD", 32'(errD), 32'd0);
      check("rst wEnVirt", 32'(wEnVirt), 32'd0);
      check("rst addressVirt", addressVirt, 32'd0);
      check("rst dataInVirt", dataInVirt, 32'd0);
      check("rst rdataI", rdataI, 32'd0);
      check("rst rdataD", rdataD, 32'd0);
      @(negedge clk); rst = 1'b1;

      // Fetch, store, load back, illegal accesses
      run(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0);
      run(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000_0004, 32'h1234_5678);
      run(1'b0, 32'h0, 1'b1, 1'b0, 32'h1000_0004, 32'h0);
      run(1'b0, 32'h0, 1'b1, 1'b0, 32'h1000_0002, 32'h0);
      run(1'b1, 32'hffff_0000, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset pulled during the ACCESS cycle of a store
      @(posedge clk); #1;
      reqD = 1'b1; weD = 1'b1; addrD = 32'h1000_0100; wdataD = 32'hcafe_f00d;
      @(negedge clk);
      @(negedge clk);
      check("store wEnVirt in ACCESS", 32'(wEnVirt), 32'd1);
      rst = 1'b0;
      #1;
      check("abort wEnVirt", 32'(wEnVirt), 32'd0);
      check("abort addressVirt", addressVirt, 32'd0);
      reqD = 1'b0; weD = 1'b0;
      exp_rd_i = '0;
      exp_rd_d = '0;
      @(negedge clk); rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("abort no ackD", 32'(ackD), 32'd0);
         check("abort no ackI", 32'(ackI), 32'd0);
      end
      check("abort rdataD", rdataD, 32'd0);
      check("abort rdataI", rdataI, 32'd0);

      run(1'b0, 32'h0, 1'b1, 1'b0, 32'h1000_0004, 32'h0);
      run(1'b0, 32'h0, 1'b1, 1'b0, 32'hffff_0004, 32'h0);

      // Both requesters held: D,D,D,D,I repeating
      @(posedge clk); #1;
      reqI = 1'b1; addrI = 32'h0000_0010;
      reqD = 1'b1; addrD = 32'h1000_0004; weD = 1'b0;
      n = 0;
      for (int c = 0; c < 120 && n < 15; c++) begin
         @(negedge clk);
         if (ackI || ackD) begin
            exp_is_i = (n % 5 == 4);
            check("starve ackI", 32'(ackI), 32'(exp_is_i));
            check("starve ackD", 32'(ackD), 32'(!exp_is_i));
            if (exp_is_i) check("starve rdataI", rdataI, exp_read(32'h0000_0010));
            else          check("starve rdataD", rdataD, exp_read(32'h1000_0004));
            n++;
            if (n == 15) begin
               @(posedge clk); #1;
               reqI = 1'b0; reqD = 1'b0;
            end
         end
      end
      reqI = 1'b0; reqD = 1'b0;
      check("starve ack count", 32'(n), 32'd15);
      exp_rd_i = exp_read(32'h0000_0010);
      exp_rd_d = exp_read(32'h1000_0004);
      @(negedge clk);

      // Randomized single and simultaneous requests
      for (int t = 0; t < 40; t++) begin
         mode = $urandom_range(0, 2);
         r_ai = rand_addr();
         r_ad = rand_addr();
         r_we = 1'($urandom_range(0, 1));
         run(mode != 1, r_ai, mode != 0, r_we, r_ad, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single virtual-address port of the memory controller between the CPU instruction-fetch requester (I, read-only) and the load/store requester (D, read/write). Each access is a req/ack transaction. The arbiter picks a winner, drives the virtual port, waits out the synchronous-memory read latency and returns data. Data has priority, with a starvation guard so fetch always makes progress. It sits between the CPU core and the memory controller.

## Interface
- MAX_D_STREAK, 4: max consecutive D grants while I is pending; then I must win.
- VIRT_IO_SEGMENT_START, 32'h_ffff_0000: base of IO region; fetches at or above it are errors.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- reqI  in  1  fetch request; held with addrI stable until ackI.
- addrI  in  32  fetch virtual address.
- rdataI  out  32  fetch data; valid in the ackI cycle, held until next ackI.
- ackI  out  1  one-cycle completion pulse for fetch.
- errI  out  1  high with ackI if fetch rejected.
- reqD  in  1  data request; held with addrD/wdataD/weD stable until ackD.
- addrD  in  32  data virtual address.
- wdataD  in  32  store data.
- weD  in  1  1 = store, 0 = load.
- rdataD  out  32  load data; valid in the ackD cycle, held until next ackD.
- ackD  out  1  one-cycle completion pulse for data.
- errD  out  1  high with ackD if access rejected.
- addressVirt  out  32  to memory controller address.
- dataInVirt  out  32  to memory controller write data.
- dataOutVirt  in  32  from memory controller; valid one cycle after address.
- wEnVirt  out  1  to memory controller write enable.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, ACK.
  - IDLE → ACCESS: on any req with a legal access.
  - IDLE → ACK: on an illegal access, which sets err.
  - ACCESS → CAPTURE → ACK → IDLE: unconditional.
- Arbitration happens in IDLE only.
  - D wins if reqD, unless streak == MAX_D_STREAK and reqI; then I wins.
  - Otherwise I wins if reqI.
- Winner's address, wdata and we are latched at the IDLE→ACCESS edge. Later changes on the inputs are ignored.
- Streak counter:
  - +1 on each D grant made while reqI is high.
  - Cleared on an I grant, or on a D grant while reqI is low.
  - Width clog2(MAX_D_STREAK+1). Saturates; never wraps.
- ACCESS: addressVirt = latched address. wEnVirt = latched we, for this cycle only. dataInVirt = latched wdata.
- CAPTURE: dataOutVirt is registered into the winner's rdata register (loads and fetches only). Stores leave rdata unchanged.
- ACK: the winner's ack is high for exactly one cycle; err is valid in the same cycle. The requester may keep req high to issue the next access; it is sampled in the following IDLE.
- Illegal accesses: no memory cycle, wEnVirt never asserted, rdata unchanged.
  - addr[1:0] != 0 on either port.
  - Fetch with addrI >= VIRT_IO_SEGMENT_START.
- Simultaneous reqI and reqD with no starvation condition: D granted, I waits in IDLE for the next arbitration.

## Timing
- Legal access: req seen in IDLE cycle N → ACCESS N+1 → CAPTURE N+2 → ack in N+3. Latency 3 cycles; peak throughput 1 access per 4 cycles.
- Illegal access: req in N → ack+err in N+1.
- Reset (rst low, asynchronous):
  - state = IDLE, all acks and errs = 0, wEnVirt = 0.
  - addressVirt, dataInVirt, rdataI, rdataD = 0; streak = 0.
- Reset mid-access aborts the transaction: no ack is issued. A store cut during ACCESS leaves that word's content undefined.
- Outputs are registered except wEnVirt, addressVirt and dataInVirt, which decode from state and latched registers. No combinational path from req to any output.

## Structure
- Shared package:
  - FSM state encoding.
  - Grant enum (GNT_I, GNT_D).
  - VIRT_IO_SEGMENT_START constant, shared with the memory controller's segment map.
- One sub-module, mem_arb_priority: combinational winner selection plus the streak counter register.

## Test plan
- Reset, then reqI=1, addrI=0x0000_0010, memory word = 0xDEAD_BEEF → ackI in the 4th cycle with rdataI=0xDEAD_BEEF, errI=0; wEnVirt never high.
- reqD store addrD=0x1000_0004, wdataD=0x1234_5678, then a load from the same address → wEnVirt high exactly 1 cycle with dataInVirt=0x1234_5678; load returns 0x1234_5678.
- reqI and reqD held high continuously, MAX_D_STREAK=4 → grant pattern D,D,D,D,I repeating; no I wait exceeds 4 D transactions.
- addrD=0x1000_0002 → ackD+errD one cycle after the request; no memory cycle; rdataD unchanged. Fetch from addrI=0xffff_0000 → errI the same way.
- Store in progress, rst pulled low in the ACCESS cycle → wEnVirt drops immediately, no ackD, state IDLE; the next request after reset completes normally.
- Load to IO address 0xffff_0004 via D → legal; ackD after 3 cycles with dataOutVirt captured.
